// File: rtl/l2_cache_nway.sv
// l2_cache_nway: N-way set-associative write-back L2 cache with tree PLRU.
// Zero-latency hits in IDLE; misses go IDLE -> [WRITEBACK ->] FILL -> IDLE,
// and the request then completes as a hit on the first IDLE cycle.
// Optional hit/miss performance counters are built when L2_PERF_CNT_EN is defined.
module l2_cache_nway #(
    parameter int WAYS      = 4,
    parameter int SETS      = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          mem_address,
    input  logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic [LINE_BITS-1:0] mem_rdata,
    output logic                 is_hit,
    output logic [31:0]          pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic [LINE_BITS-1:0] pmem_rdata
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 27 - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t             state_q, state_d;
    logic [WAY_W-1:0]   victim_q, victim_c, hit_way;
    logic [WAYS-1:0]    way_hit;
    logic               req, any_hit, hit, miss_start, fill_done;

    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      dirty_q [SETS];
    logic [WAYS-2:0]      plru_q  [SETS];
    logic [TAG_W-1:0]     tag_q   [SETS][WAYS];
    logic [LINE_BITS-1:0] data_q  [SETS][WAYS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_offset;

    assign idx           = mem_address[5 +: IDX_W];
    assign req_tag       = mem_address[31 -: TAG_W];
    assign unused_offset = ^mem_address[4:0];

    // Follow the tree bits from the root; each bit names the subtree holding the victim.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        int   node;
        int   way;
        logic b;
        node = 0;
        way  = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int n = 0; n < WAYS - 1; n++)
                if (n == node) b = bits[n];
            way  = way * 2 + int'(b);
            node = 2 * node + 1 + int'(b);
        end
        return WAY_W'(way);
    endfunction

    // Point every node on the path to the touched way toward the other subtree.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                    input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] res;
        int              node;
        logic            dir;
        res  = bits;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = ((int'(way) >> (WAY_W - 1 - l)) & 1) != 0;
            for (int n = 0; n < WAYS - 1; n++)
                if (n == node) res[n] = ~dir;
            node = 2 * node + 1 + int'(dir);
        end
        return res;
    endfunction

    // Tag compare, lowest-numbered hit way, and victim choice for the addressed set.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        way_hit  = '0;
        hit_way  = '0;
        victim_c = plru_victim(plru_q[idx]);
        for (int w = 0; w < WAYS; w++)
            way_hit[w] = valid_q[idx][w] && (tag_q[idx][w] == req_tag);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w])       hit_way  = WAY_W'(w);
            if (!valid_q[idx][w]) victim_c = WAY_W'(w);
        end
    end

    assign req        = mem_read | mem_write;
    assign any_hit    = |way_hit;
    assign hit        = (state_q == IDLE) && req && any_hit;
    assign miss_start = (state_q == IDLE) && req && !any_hit;
    assign fill_done  = (state_q == FILL) && pmem_resp;

    assign is_hit    = hit;
    assign mem_resp  = hit;
    assign mem_rdata = data_q[idx][hit_way];

    // Next-state logic and physical-memory request outputs.
    always_comb begin
        state_d      = state_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {mem_address[31:5], 5'b0};
        pmem_wdata   = data_q[idx][victim_q];
        case (state_q)
            IDLE: begin
                if (miss_start)
                    state_d = (valid_q[idx][victim_c] && dirty_q[idx][victim_c]) ? WRITEBACK : FILL;
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx][victim_q], idx, 5'b0};
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, victim latch, and the reset-cleared valid/dirty/PLRU arrays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (miss_start) victim_q <= victim_c;
            if (hit) begin
                plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                if (mem_write) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

    // Tag and line storage, written on fill completion or a write hit.
    // NOTE: no reset here; valid bits gate every use, so clearing the arrays buys nothing.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[idx][victim_q] <= pmem_rdata;
            tag_q[idx][victim_q]  <= req_tag;
        end else if (hit && mem_write) begin
            data_q[idx][hit_way] <= mem_wdata;
        end
    end

`ifdef L2_PERF_CNT_EN
    // Saturating hit/miss counters; a miss counts once, on leaving IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && hit_count != 32'hFFFF_FFFF)         hit_count  <= hit_count + 32'd1;
            if (miss_start && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed bench for l2_cache_nway (WAYS=4, SETS=16). The bench plays the
// arbiter and a fixed-latency physical memory whose lines are a function of address.
module tb_l2_cache_nway;

    localparam int PMEM_LAT = 3;
    localparam int MAX_CYC  = 200;

    logic         clk, rst_n;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_read, mem_write, mem_resp, is_hit;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_read, pmem_write, pmem_resp;
`ifdef L2_PERF_CNT_EN
    logic [31:0]  hit_count, miss_count;
`endif

    l2_cache_nway #(.WAYS(4), .SETS(16), .LINE_BITS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .is_hit(is_hit),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
`ifdef L2_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_cmp, n_fail;
    int           wb_count, fill_count, wb_cyc, fill_cyc, busy;
    logic [31:0]  wb_addr, fill_addr;
    logic [255:0] wb_data;
    logic         both_seen;

    function automatic logic [255:0] line_of(input logic [31:0] a);
        return {8{a ^ 32'h1357_9BDF}};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1. Holds the request until mem_resp, serving pmem
    // with PMEM_LAT-cycle responses, then drops it after the completing edge.
    task automatic do_access(input logic [31:0] addr, input logic wr, input logic [255:0] wd,
                             output logic first_hit, output int lat, output logic [255:0] rd);
        mem_address = addr;
        mem_write   = wr;
        mem_read    = !wr;
        mem_wdata   = wd;
        #1;
        first_hit = is_hit;
        lat  = 0;
        busy = 0;
        while (!mem_resp && lat < MAX_CYC) begin
            if (pmem_read && pmem_write) both_seen = 1'b1;
            if (pmem_read || pmem_write) begin
                busy++;
                if (busy == PMEM_LAT) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = line_of(pmem_address);
                    if (pmem_write) begin
                        wb_count++;
                        wb_addr = pmem_address;
                        wb_data = pmem_wdata;
                        wb_cyc  = lat;
                    end else begin
                        fill_count++;
                        fill_addr = pmem_address;
                        fill_cyc  = lat;
                    end
                    busy = 0;
                end
            end
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            lat++;
            #1;
        end
        check("resp_seen", 256'(mem_resp), 256'(1));
        rd = mem_rdata;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    logic         fh;
    int           lat, k;
    logic [255:0] rd;
    logic [255:0] w_a5, w2, w3, w4, w5;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0; wb_count = 0; fill_count = 0;
        wb_cyc = 0; fill_cyc = 0; busy = 0; both_seen = 1'b0;
        wb_addr = '0; fill_addr = '0; wb_data = '0;
        w_a5 = {32{8'hA5}};
        w2 = {8{32'h2222_0002}}; w3 = {8{32'h3333_0003}};
        w4 = {8{32'h4444_0004}}; w5 = {8{32'h5555_0005}};
        rst_n = 1'b0; mem_address = '0; mem_wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
        pmem_resp = 1'b0; pmem_rdata = '0;

        // Reset state: outputs quiet even with a request present.
        repeat (2) @(posedge clk);
        #1;
        mem_address = 32'h0000_1000; mem_read = 1'b1;
        #1;
        check("rst_mem_resp", 256'(mem_resp), 256'(0));
        check("rst_is_hit", 256'(is_hit), 256'(0));
        check("rst_pmem_read", 256'(pmem_read), 256'(0));
        check("rst_pmem_write", 256'(pmem_write), 256'(0));
        mem_read = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Cold read of 0x1000: fill only, resp one cycle after fill resp.
        do_access(32'h0000_1000, 1'b0, '0, fh, lat, rd);
        check("cold_first_hit", 256'(fh), 256'(0));
        check("cold_no_wb", 256'(wb_count), 256'(0));
        check("cold_fill_cnt", 256'(fill_count), 256'(1));
        check("cold_fill_addr", 256'(fill_addr), 256'(32'h0000_1000));
        check("cold_rdata", rd, line_of(32'h0000_1000));
        check("cold_resp_lat", 256'(lat - fill_cyc), 256'(1));

        // Write hit: same-cycle response, no pmem traffic; read back.
        do_access(32'h0000_1000, 1'b1, w_a5, fh, lat, rd);
        check("wrhit_first_hit", 256'(fh), 256'(1));
        check("wrhit_lat", 256'(lat), 256'(0));
        check("wrhit_fill_cnt", 256'(fill_count), 256'(1));
        check("wrhit_wb_cnt", 256'(wb_count), 256'(0));
        do_access(32'h0000_1000, 1'b0, '0, fh, lat, rd);
        check("rdhit_first_hit", 256'(fh), 256'(1));
        check("rdhit_rdata", rd, w_a5);

        // Dirty writes to three more set-0 tags fill ways 1..3 without writeback.
        do_access(32'h0000_2000, 1'b1, w2, fh, lat, rd);
        check("w2_miss", 256'(fh), 256'(0));
        do_access(32'h0000_3000, 1'b1, w3, fh, lat, rd);
        check("w3_miss", 256'(fh), 256'(0));
        do_access(32'h0000_4000, 1'b1, w4, fh, lat, rd);
        check("w4_miss", 256'(fh), 256'(0));
        check("fill4_no_wb", 256'(wb_count), 256'(0));

        // Fifth tag: PLRU after touches 0,1,2,3 points at way 0 (0x1000, dirty A5).
        do_access(32'h0000_5000, 1'b1, w5, fh, lat, rd);
        check("w5_miss", 256'(fh), 256'(0));
        check("w5_wb_cnt", 256'(wb_count), 256'(1));
        check("w5_wb_addr", 256'(wb_addr), 256'(32'h0000_1000));
        check("w5_wb_data", wb_data, w_a5);
        check("w5_wb_before_fill", 256'(wb_cyc < fill_cyc), 256'(1));

        // Touches 0,1,2,3 then 0: next miss victimises way 2 (0x3000, dirty w3).
        do_access(32'h0000_6000, 1'b0, '0, fh, lat, rd);
        check("plru_wb_addr", 256'(wb_addr), 256'(32'h0000_3000));
        check("plru_wb_data", wb_data, w3);
        check("plru_rdata", rd, line_of(32'h0000_6000));

        // Surviving ways still hit with their written data.
        do_access(32'h0000_2000, 1'b0, '0, fh, lat, rd);
        check("keep2_hit", 256'(fh), 256'(1));
        check("keep2_data", rd, w2);
        do_access(32'h0000_4000, 1'b0, '0, fh, lat, rd);
        check("keep4_hit", 256'(fh), 256'(1));
        check("keep4_data", rd, w4);
        do_access(32'h0000_5000, 1'b0, '0, fh, lat, rd);
        check("keep5_hit", 256'(fh), 256'(1));
        check("keep5_data", rd, w5);

        // Reset two cycles into FILL: pmem_read drops without a clock edge.
        mem_address = 32'h0000_7020; mem_read = 1'b1; mem_write = 1'b0;
        k = 0;
        while (!pmem_read && k < 20) begin
            @(posedge clk); #2; k++;
        end
        check("abort_fill_started", 256'(pmem_read), 256'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_pmem_read", 256'(pmem_read), 256'(0));
        check("abort_mem_resp", 256'(mem_resp), 256'(0));
        mem_read = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        mem_address = 32'h0000_2000; mem_read = 1'b1;
        #1;
        check("post_rst_valid_clr", 256'(is_hit), 256'(0));
        #1; mem_read = 1'b0;
        @(posedge clk); #1;
        do_access(32'h0000_7020, 1'b0, '0, fh, lat, rd);
        check("post_abort_miss", 256'(fh), 256'(0));
        check("post_abort_fill_addr", 256'(fill_addr), 256'(32'h0000_7020));
        check("post_abort_rdata", rd, line_of(32'h0000_7020));
        check("never_both_pmem", 256'(both_seen), 256'(0));

`ifdef L2_PERF_CNT_EN
        // Counters: 3 misses plus 7 hits -> 3 misses, 10 hits (completions count).
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        check("cnt_rst_hit", 256'(hit_count), 256'(0));
        check("cnt_rst_miss", 256'(miss_count), 256'(0));
        do_access(32'h0000_1000, 1'b0, '0, fh, lat, rd);
        do_access(32'h0000_2000, 1'b0, '0, fh, lat, rd);
        do_access(32'h0000_3000, 1'b0, '0, fh, lat, rd);
        for (int i = 0; i < 7; i++)
            do_access(32'h0000_1000 + 32'(i % 3) * 32'h1000, 1'b0, '0, fh, lat, rd);
        check("cnt_miss", 256'(miss_count), 256'(3));
        check("cnt_hit", 256'(hit_count), 256'(10));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
